// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: logic/arith ops return a registered result one cycle after start (done pulse);
// signed mult iterates WIDTH cycles with busy high, done after WIDTH+1 cycles; start is ignored unless IDLE.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       ALU_control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       shamt,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] prod_hi,
  output logic             zero,
  output logic             ovf,
  output logic             illegal,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLL = 4'b1111;
  localparam logic [3:0] OP_MUL = 4'b1001;

  localparam logic [5:0] SH_LIM = 6'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             illegal_q, illegal_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic             sign_q, sign_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0]   sum, diff, a_abs, b_abs, op_res;
  logic               op_ovf, op_ill;
  logic [WIDTH:0]     acc_add;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;

  assign sum   = A + B;
  assign diff  = A - B;
  // Magnitude of the most-negative value wraps to itself, which is correct read as unsigned.
  assign a_abs = A[WIDTH-1] ? -A : A;
  assign b_abs = B[WIDTH-1] ? -B : B;

  assign acc_add  = {1'b0, hi_q} + {1'b0, mcand_q & {WIDTH{lo_q[0]}}};
  assign prod_mag = {hi_q, lo_q};
  assign prod_fix = sign_q ? -prod_mag : prod_mag;

  always_comb begin
    op_res = '0;
    op_ovf = 1'b0;
    op_ill = 1'b0;
    case (ALU_control)
      OP_AND: op_res = A & B;
      OP_OR:  op_res = A | B;
      OP_ADD: begin
        op_res = sum;
        op_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        op_res = diff;
        op_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT: op_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_NOR: op_res = ~(A | B);
      OP_SLL: op_res = ({1'b0, shamt} >= SH_LIM) ? '0 : (B << shamt);
      default: op_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    prod_hi_d = prod_hi_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    illegal_d = illegal_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mcand_d   = mcand_q;
    sign_d    = sign_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (ALU_control == OP_MUL) begin
            sign_d  = A[WIDTH-1] ^ B[WIDTH-1];
            mcand_d = a_abs;
            lo_d    = b_abs;
            hi_d    = '0;
            cnt_d   = CW'(WIDTH);
            state_d = S_MUL;
          end else begin
            result_d  = op_res;
            zero_d    = (op_res == '0);
            ovf_d     = op_ovf;
            illegal_d = op_ill;
            prod_hi_d = '0;
            done_d    = 1'b1;
          end
        end
      end
      S_MUL: begin
        // Add-then-shift keeps the carry out of the accumulator in the product.
        {hi_d, lo_d} = {acc_add, lo_q[WIDTH-1:1]};
        cnt_d        = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        {prod_hi_d, result_d} = prod_fix;
        zero_d    = (prod_fix == '0);
        ovf_d     = 1'b0;
        illegal_d = 1'b0;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      prod_hi_q <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
      sign_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      prod_hi_q <= prod_hi_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      illegal_q <= illegal_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mcand_q   <= mcand_d;
      sign_q    <= sign_d;
      cnt_q     <= cnt_d;
    end
  end

  assign result  = result_q;
  assign prod_hi = prod_hi_q;
  assign zero    = zero_q;
  assign ovf     = ovf_q;
  assign illegal = illegal_q;
  assign busy    = (state_q == S_MUL);
  assign done    = done_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (WIDTH=32): hand-computed vectors, immediate-assertion checks.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  ALU_control;
  logic [31:0] A, B;
  logic [4:0]  shamt;
  logic [31:0] result, prod_hi;
  logic        zero, ovf, illegal, busy, done;

  int checks   = 0;
  int failures = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ALU_control(ALU_control),
    .A(A), .B(B), .shamt(shamt), .result(result), .prod_hi(prod_hi),
    .zero(zero), .ovf(ovf), .illegal(illegal), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents an op for one edge; returns 1 time unit after the sampling edge.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    ALU_control = op;
    A = a;
    B = b;
    shamt = sh;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Starts a mult and waits (bounded) for done; optionally pokes start while busy.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input bit poke,
                         output int done_edge, output int busy_cnt);
    do_op(4'b1001, a, b, 5'd0);
    busy_cnt  = busy ? 1 : 0;
    done_edge = 0;
    for (int e = 1; e <= 40 && done_edge == 0; e++) begin
      if (poke && e == 5) begin
        ALU_control = 4'b0010;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) done_edge = e;
    end
  endtask

  initial begin
    int  de, bc;
    bit  seen;
    reset_n = 1'b0;
    start = 1'b0;
    ALU_control = 4'd0;
    A = '0;
    B = '0;
    shamt = '0;
    tick();
    tick();
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_flags", 64'({prod_hi, zero, ovf, illegal, busy, done}), 64'd0);
    reset_n = 1'b1;
    tick();

    // Reset during a mult aborts it
    do_op(4'b1001, 32'hFFFF_FFFD, 32'd7, 5'd0);
    repeat (9) tick();
    chk("midmul_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("midmul_reset_out", 64'({result, prod_hi, zero, ovf, illegal, busy, done}), 64'd0);
    tick();
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("midmul_no_done", 64'(seen), 64'd0);

    do_op(4'b0010, 32'h7FFF_FFFF, 32'd1, 5'd0);
    chk("add_done", 64'(done), 64'd1);
    chk("add_result", 64'(result), 64'h8000_0000);
    chk("add_ovf", 64'({ovf, zero, illegal}), 64'b100);
    tick();
    chk("add_done_pulse", 64'(done), 64'd0);
    chk("add_hold", 64'(result), 64'h8000_0000);

    do_op(4'b0110, 32'd5, 32'd5, 5'd0);
    chk("sub_result", 64'(result), 64'd0);
    chk("sub_zero_ovf", 64'({zero, ovf}), 64'b10);

    do_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0);
    chk("slt_result", 64'(result), 64'd1);

    do_op(4'b1111, 32'd0, 32'd1, 5'd31);
    chk("sll_result", 64'(result), 64'h8000_0000);

    do_op(4'b1100, 32'd0, 32'd0, 5'd0);
    chk("nor_result", 64'(result), 64'hFFFF_FFFF);
    chk("nor_zero", 64'(zero), 64'd0);

    run_mul(32'hFFFF_FFFD, 32'd7, 1'b1, de, bc);
    chk("mul_latency", 64'(de), 64'd33);
    chk("mul_busy_cycles", 64'(bc), 64'd32);
    chk("mul_product", {prod_hi, result}, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("mul_flags", 64'({zero, ovf, illegal, busy}), 64'b0000);
    tick();
    chk("mul_done_pulse", 64'(done), 64'd0);

    run_mul(32'h8000_0000, 32'h8000_0000, 1'b0, de, bc);
    chk("minmin_latency", 64'(de), 64'd33);
    chk("minmin_product", {prod_hi, result}, 64'h4000_0000_0000_0000);
    chk("minmin_zero", 64'(zero), 64'd0);

    do_op(4'b0011, 32'd9, 32'd9, 5'd0);
    chk("illegal_done", 64'(done), 64'd1);
    chk("illegal_flags", 64'({result, prod_hi, illegal}), 64'd1);

    run_mul(32'd2, 32'd3, 1'b0, de, bc);
    chk("b2b_mul_product", {prod_hi, result}, 64'd6);
    chk("b2b_mul_illegal_clr", 64'(illegal), 64'd0);
    do_op(4'b0010, 32'd10, 32'd20, 5'd0);
    chk("b2b_add_done", 64'(done), 64'd1);
    chk("b2b_add_result", {prod_hi, result}, 64'd30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation timeout");
  end

endmodule
